rally_scorer: RTL and testbench
===============================

RALLY_SCORER -- requirements
Module: rally_scorer

Interface
REQ-001 SHALL have parameter PADDLE_HALF_W, default 40, meaning hit-window half-width in pixels about paddle_x.
REQ-002 SHALL have parameter PADDLE_HALF_H, default 30, meaning hit-window half-height in pixels about paddle_y.
REQ-003 SHALL have parameter Z_PLANE, default 16, meaning ball depth at or below which the paddle plane is reached.
REQ-004 SHALL have port frame_clk  input  1  sole clock, one edge per video frame.
REQ-005 SHALL have port game_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port level_rst  input  1  synchronous per-level clear from the level sequencer.
REQ-007 SHALL have port pause  input  1  freeze; no scoring while high.
REQ-008 SHALL have ports ball_x, ball_y, ball_z  input  10 each  unsigned ball position.
REQ-009 SHALL have port ball_toward  input  1  high while the ball moves toward the player (z decreasing).
REQ-010 SHALL have ports paddle_x, paddle_y  input  10 each  unsigned paddle centre.
REQ-011 SHALL have port score  output  8  hits scored in the current level.
REQ-012 SHALL have port hit  output  1  one-frame pulse on a successful return.
REQ-013 SHALL have port miss  output  1  one-frame pulse on a missed ball.

Function
REQ-014 SHALL implement states IDLE, APPROACH, RETURN, MISSED; all outputs registered.
REQ-015 SHALL treat the ball as in-window when |ball_x-paddle_x| <= PADDLE_HALF_W and |ball_y-paddle_y| <= PADDLE_HALF_H, using 11-bit signed differences (no wrap).
REQ-016 IDLE: with pause=0, SHALL go to APPROACH if ball_toward=1, else to RETURN; no evaluation in the IDLE frame.
REQ-017 APPROACH: when ball_z <= Z_PLANE and in-window, SHALL assert hit for one frame, increment score, and go to RETURN.
REQ-018 APPROACH: when ball_z <= Z_PLANE and not in-window, SHALL assert miss for one frame and go to MISSED.
REQ-019 RETURN: SHALL go to APPROACH only when ball_toward=1 and ball_z > Z_PLANE (no double count at the plane).
REQ-020 MISSED: SHALL hold score, keep hit=miss=0, and stay until level_rst or game_rst.
REQ-021 hit/miss SHALL appear on the frame_clk edge that samples the crossing (1-frame latency); never both high.
REQ-022 score SHALL saturate at 255; a hit at 255 still pulses hit.
REQ-023 pause=1 SHALL hold state and score and force hit=miss=0; resuming continues from the held state.
REQ-024 level_rst=1 SHALL set IDLE, score=0, hit=miss=0 on the next edge, regardless of pause or state.

Reset
REQ-025 game_rst SHALL have priority over level_rst and pause, giving IDLE, score=0, hit=0, miss=0 (and any offsets =0).
REQ-026 Reset SHALL take effect mid-APPROACH without emitting hit or miss.

Configuration
REQ-027 With RALLY_SPIN_EN defined, SHALL add outputs hit_dx, hit_dy (signed 11-bit, ball minus paddle) captured on each hit, held otherwise, cleared by game_rst/level_rst.
REQ-028 Without RALLY_SPIN_EN, hit_dx/hit_dy SHALL not exist and behaviour is otherwise identical.

Structure
REQ-029 SHALL place the state enum, 10-bit coordinate typedef and the default window constants in shared package pong_pkg.
REQ-030 SHALL use one sub-module, hit_window, combinationally computing the in-window flag (and offsets when RALLY_SPIN_EN).

Verification
REQ-031 Reset, pause=0, ball_toward=1, ball_z 100->16 at (320,240), paddle (330,250) -> hit pulse 1 frame, score 0->1, state RETURN.
REQ-032 Same approach with paddle (400,240) (dx=80) -> miss pulse 1 frame, score unchanged, further crossings produce no pulses until level_rst.
REQ-033 Ball stays at z=10 with ball_toward=1 for 5 frames after a hit -> score stays 1, no second hit.
REQ-034 pause=1 on the crossing frame -> no pulse; pause=0 next frame with ball still at z=10 in-window -> hit, score+1.
REQ-035 Score preloaded to 255 via 255 hits, one more hit -> hit pulses, score stays 255; then level_rst and pause high together -> score 0, IDLE.
REQ-036 game_rst and level_rst asserted together during APPROACH at crossing frame -> no hit/miss, all outputs 0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and defaults for the rally scorer: FSM states, coordinates, window constants.
package pong_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StApproach = 2'd1,
    StReturn   = 2'd2,
    StMissed   = 2'd3
  } rally_state_e;

  typedef logic [9:0]        coord_t;
  typedef logic signed [10:0] offset_t;

  localparam int unsigned DefPaddleHalfW = 40;
  localparam int unsigned DefPaddleHalfH = 30;
  localparam int unsigned DefZPlane      = 16;

  // Zero-extend before subtracting so the difference never wraps.
  function automatic offset_t coord_diff(input coord_t a, input coord_t b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [10:0] abs_offset(input offset_t d);
    return d[10] ? 11'(-d) : 11'(d);
  endfunction

endpackage

// File: rtl/hit_window.sv
// Combinational paddle hit-window test; exports ball-minus-paddle offsets when RALLY_SPIN_EN.
module hit_window
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_HALF_W = DefPaddleHalfW,
  parameter int unsigned PADDLE_HALF_H = DefPaddleHalfH
) (
  input  coord_t  ball_x_i,
  input  coord_t  ball_y_i,
  input  coord_t  paddle_x_i,
  input  coord_t  paddle_y_i,
  output logic    in_window_o
`ifdef RALLY_SPIN_EN
  ,
  output offset_t dx_o,
  output offset_t dy_o
`endif
);

  localparam logic [10:0] HalfW = 11'(PADDLE_HALF_W);
  localparam logic [10:0] HalfH = 11'(PADDLE_HALF_H);

  offset_t dx, dy;

  always_comb begin
    dx          = coord_diff(ball_x_i, paddle_x_i);
    dy          = coord_diff(ball_y_i, paddle_y_i);
    in_window_o = (abs_offset(dx) <= HalfW) && (abs_offset(dy) <= HalfH);
  end

`ifdef RALLY_SPIN_EN
  assign dx_o = dx;
  assign dy_o = dy;
`endif

endmodule

// File: rtl/rally_scorer.sv
// Per-frame rally scoring FSM with registered hit/miss pulses and saturating score.
// Optional RALLY_SPIN_EN adds hit_dx/hit_dy offsets captured on each hit.
module rally_scorer
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_HALF_W = DefPaddleHalfW,
  parameter int unsigned PADDLE_HALF_H = DefPaddleHalfH,
  parameter int unsigned Z_PLANE       = DefZPlane
) (
  input  logic        frame_clk,
  input  logic        game_rst,
  input  logic        level_rst,
  input  logic        pause,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  ball_z,
  input  logic        ball_toward,
  input  logic [9:0]  paddle_x,
  input  logic [9:0]  paddle_y,
  output logic [7:0]  score,
  output logic        hit,
  output logic        miss
`ifdef RALLY_SPIN_EN
  ,
  output logic signed [10:0] hit_dx,
  output logic signed [10:0] hit_dy
`endif
);

  localparam coord_t ZPlane = coord_t'(Z_PLANE);

  rally_state_e state_q, state_d;
  logic [7:0]   score_q, score_d;
  logic         hit_q, hit_d;
  logic         miss_q, miss_d;
  logic         in_window;
  logic         at_plane;

`ifdef RALLY_SPIN_EN
  offset_t win_dx, win_dy;
  offset_t dx_q, dx_d, dy_q, dy_d;
`endif

  hit_window #(
    .PADDLE_HALF_W (PADDLE_HALF_W),
    .PADDLE_HALF_H (PADDLE_HALF_H)
  ) u_hit_window (
    .ball_x_i    (ball_x),
    .ball_y_i    (ball_y),
    .paddle_x_i  (paddle_x),
    .paddle_y_i  (paddle_y),
    .in_window_o (in_window)
`ifdef RALLY_SPIN_EN
    ,
    .dx_o        (win_dx),
    .dy_o        (win_dy)
`endif
  );

  assign at_plane = (ball_z <= ZPlane);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
`ifdef RALLY_SPIN_EN
    dx_d    = dx_q;
    dy_d    = dy_q;
`endif
    if (level_rst) begin
      state_d = StIdle;
      score_d = 8'd0;
`ifdef RALLY_SPIN_EN
      dx_d    = '0;
      dy_d    = '0;
`endif
    end else if (!pause) begin
      case (state_q)
        StIdle: state_d = ball_toward ? StApproach : StReturn;
        StApproach: begin
          if (at_plane) begin
            if (in_window) begin
              hit_d   = 1'b1;
              score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
              state_d = StReturn;
`ifdef RALLY_SPIN_EN
              dx_d    = win_dx;
              dy_d    = win_dy;
`endif
            end else begin
              miss_d  = 1'b1;
              state_d = StMissed;
            end
          end
        end
        // Re-arm only once the ball is beyond the plane so a resting ball cannot score twice.
        StReturn: if (ball_toward && !at_plane) state_d = StApproach;
        StMissed: state_d = StMissed;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (game_rst) begin
      state_q <= StIdle;
      score_q <= 8'd0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
`ifdef RALLY_SPIN_EN
      dx_q    <= '0;
      dy_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
`ifdef RALLY_SPIN_EN
      dx_q    <= dx_d;
      dy_q    <= dy_d;
`endif
    end
  end

  assign score = score_q;
  assign hit   = hit_q;
  assign miss  = miss_q;
`ifdef RALLY_SPIN_EN
  assign hit_dx = dx_q;
  assign hit_dy = dy_q;
`endif

endmodule

// File: tb/tb_rally_scorer.sv
// Scoreboard bench for rally_scorer: each frame pushes expected {hit,miss,score}, popped after the edge.
module tb_rally_scorer;

  logic       frame_clk = 1'b0;
  logic       game_rst, level_rst, pause, ball_toward;
  logic [9:0] ball_x, ball_y, ball_z, paddle_x, paddle_y;
  logic [7:0] score;
  logic       hit, miss;
`ifdef RALLY_SPIN_EN
  logic signed [10:0] hit_dx, hit_dy;
`endif

  always #5 frame_clk = ~frame_clk;

  rally_scorer dut (
    .frame_clk   (frame_clk),
    .game_rst    (game_rst),
    .level_rst   (level_rst),
    .pause       (pause),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_z      (ball_z),
    .ball_toward (ball_toward),
    .paddle_x    (paddle_x),
    .paddle_y    (paddle_y),
    .score       (score),
    .hit         (hit),
    .miss        (miss)
`ifdef RALLY_SPIN_EN
    ,
    .hit_dx      (hit_dx),
    .hit_dy      (hit_dy)
`endif
  );

  typedef struct {
    int bx, by, bz, px, py;
    bit tw, ps, lr, gr;
    bit h, m;
    int s;
  } frame_t;

  logic [9:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Drive one frame of inputs and queue the outputs that frame must produce.
  task automatic apply(input frame_t f);
    ball_x      = 10'(f.bx);
    ball_y      = 10'(f.by);
    ball_z      = 10'(f.bz);
    paddle_x    = 10'(f.px);
    paddle_y    = 10'(f.py);
    ball_toward = f.tw;
    pause       = f.ps;
    level_rst   = f.lr;
    game_rst    = f.gr;
    exp_q.push_back({f.h, f.m, 8'(f.s)});
  endtask

  task automatic test_reset();
    logic [9:0] e, got;
    for (int i = 0; i < 2; i++) begin
      apply(frame_t'{0, 0, 100, 0, 0, 1, 1, 1, 1, 0, 0, 0});
      tick();
      got = {hit, miss, score};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got hit=%b miss=%b score=%0d, want hit=%b miss=%b score=%0d",
                 i, got[9], got[8], got[7:0], e[9], e[8], e[7:0]);
      end
    end
  endtask

  // Approach to a hit, then the ball rests at the plane for five frames.
  task automatic test_hit();
    int zs[11] = '{100, 80, 60, 40, 20, 16, 10, 10, 10, 10, 10};
    logic [9:0] e, got;
    apply(frame_t'{320, 240, 100, 330, 250, 1, 0, 0, 1, 0, 0, 0});
    tick();
    void'(exp_q.pop_front());
    for (int i = 0; i < 11; i++) begin
      apply(frame_t'{320, 240, zs[i], 330, 250, 1, 0, 0, 0,
                     (i == 5), 0, (i >= 5) ? 1 : 0});
      tick();
      got = {hit, miss, score};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL hit[%0d]: got hit=%b miss=%b score=%0d, want hit=%b miss=%b score=%0d",
                 i, got[9], got[8], got[7:0], e[9], e[8], e[7:0]);
      end
    end
`ifdef RALLY_SPIN_EN
    checks++;
    if (hit_dx !== -11'sd10 || hit_dy !== -11'sd10) begin
      errors++;
      $display("FAIL spin_offsets: got dx=%0d dy=%0d, want dx=-10 dy=-10", hit_dx, hit_dy);
    end
`endif
  endtask

  task automatic test_miss();
    frame_t fr[$];
    logic [9:0] e, got;
    fr.push_back(frame_t'{320, 240, 100, 400, 240, 1, 0, 1, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240, 100, 400, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  60, 400, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  16, 400, 240, 1, 0, 0, 0, 0, 1, 0});
    fr.push_back(frame_t'{320, 240,  16, 400, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240, 100, 400, 240, 0, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240, 100, 400, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 400, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 1, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 0, 0, 0, 1, 0, 1});
    foreach (fr[i]) begin
      apply(fr[i]);
      tick();
      got = {hit, miss, score};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL miss[%0d]: got hit=%b miss=%b score=%0d, want hit=%b miss=%b score=%0d",
                 i, got[9], got[8], got[7:0], e[9], e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_window_edges();
    int cs[9][5] = '{'{320, 240, 360, 240, 1}, '{320, 240, 361, 240, 0},
                     '{400, 240, 360, 240, 1}, '{401, 240, 360, 240, 0},
                     '{320, 210, 320, 240, 1}, '{320, 271, 320, 240, 0},
                     '{5, 5, 45, 35, 1},       '{0, 0, 1000, 0, 0},
                     '{1023, 1023, 983, 993, 1}};
    logic [9:0] e, got;
    for (int c = 0; c < 9; c++) begin
      for (int f = 0; f < 3; f++) begin
        apply(frame_t'{cs[c][0], cs[c][1], (f == 2) ? 16 : 100, cs[c][2], cs[c][3],
                       1, 0, (f == 0), 0,
                       (f == 2) && cs[c][4] != 0, (f == 2) && cs[c][4] == 0,
                       (f == 2 && cs[c][4] != 0) ? 1 : 0});
        tick();
        got = {hit, miss, score};
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL window[%0d.%0d]: got hit=%b miss=%b score=%0d, want hit=%b miss=%b score=%0d",
                   c, f, got[9], got[8], got[7:0], e[9], e[8], e[7:0]);
        end
      end
    end
  endtask

  task automatic test_pause();
    frame_t fr[$];
    logic [9:0] e, got;
    fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 1, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 1, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 1, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 0, 0, 0, 1, 0, 1});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 1, 0, 0, 0, 0, 1});
    foreach (fr[i]) begin
      apply(fr[i]);
      tick();
      got = {hit, miss, score};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pause[%0d]: got hit=%b miss=%b score=%0d, want hit=%b miss=%b score=%0d",
                 i, got[9], got[8], got[7:0], e[9], e[8], e[7:0]);
      end
    end
  endtask

  // 256 hits drive the score into saturation, then level_rst under pause clears it.
  task automatic test_saturate();
    frame_t fr[$];
    logic [9:0] e, got;
    int model = 0;
    fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 1, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 0, 0, 0, 0, 0});
    for (int k = 0; k < 256; k++) begin
      model = (model < 255) ? model + 1 : 255;
      fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 0, 0, 0, 1, 0, model});
      fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 0, 0, 0, 0, model});
    end
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 1, 1, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 1, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 0, 0, 0, 1, 0, 1});
    foreach (fr[i]) begin
      apply(fr[i]);
      tick();
      got = {hit, miss, score};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL saturate[%0d]: got hit=%b miss=%b score=%0d, want hit=%b miss=%b score=%0d",
                 i, got[9], got[8], got[7:0], e[9], e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_reset_priority();
    frame_t fr[$];
    logic [9:0] e, got;
    fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 1, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 0, 0, 0, 1, 0, 1});
    fr.push_back(frame_t'{320, 240, 100, 320, 240, 1, 0, 0, 0, 0, 0, 1});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 1, 1, 1, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 320, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 700, 240, 1, 0, 0, 1, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 700, 240, 1, 0, 0, 0, 0, 0, 0});
    fr.push_back(frame_t'{320, 240,  10, 700, 240, 1, 0, 0, 0, 0, 1, 0});
    foreach (fr[i]) begin
      apply(fr[i]);
      tick();
      got = {hit, miss, score};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rst_priority[%0d]: got hit=%b miss=%b score=%0d, want hit=%b miss=%b score=%0d",
                 i, got[9], got[8], got[7:0], e[9], e[8], e[7:0]);
      end
    end
  endtask

  initial begin
    game_rst    = 1'b1;
    level_rst   = 1'b0;
    pause       = 1'b0;
    ball_toward = 1'b0;
    ball_x      = '0;
    ball_y      = '0;
    ball_z      = '0;
    paddle_x    = '0;
    paddle_y    = '0;
    test_reset();
    test_hit();
    test_miss();
    test_window_edges();
    test_pause();
    test_saturate();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
